// File: rtl/sqrt_pkg.sv
// Shared constants and types for the square-root reconstruction stage.
//   SQRT_QW : root width
//   SQRT_RW : remainder width (QW+1)
//   SQRT_DW : radicand width (2*QW)
//   SQRT_AW : accumulator width (DW+2, wide enough for Q*Q + R without wrap)
//   SQRT_CW : bit-position counter width
package sqrt_pkg;

    localparam int unsigned SQRT_QW = 16;
    localparam int unsigned SQRT_RW = SQRT_QW + 1;
    localparam int unsigned SQRT_DW = 2 * SQRT_QW;
    localparam int unsigned SQRT_AW = SQRT_DW + 2;
    localparam int unsigned SQRT_CW = $clog2(SQRT_QW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } sqrt_rec_state_t;

endpackage : sqrt_pkg

// File: rtl/sqrt_reconstruct_seq.sv
// Sequential radicand reconstruction: D = Q*Q + R using a radix-2 shift-add
// squarer that retires one multiplier bit per clock.
//
// Optional feature macro: SQRT_RANGE_CHECK_EN
//   defined   : out_err flags an illegal pair (R > 2*Q), captured at accept
//   undefined : no comparator, out_err is constant 0
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   Q/R pair offered
//   in_ready   pair can be accepted (IDLE only)
//   in_q       root (QW bits)
//   in_r       remainder (RW bits)
//   out_valid  result held valid
//   out_ready  downstream accepts result
//   out_d      low DW bits of Q*Q + R
//   out_ovf    Q*Q + R does not fit in DW bits
//   out_err    illegal pair flag
module sqrt_reconstruct_seq
    import sqrt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SQRT_QW-1:0] in_q,
    input  logic [SQRT_RW-1:0] in_r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SQRT_DW-1:0] out_d,
    output logic               out_ovf,
    output logic               out_err
);

    localparam int unsigned QW = SQRT_QW;
    localparam int unsigned DW = SQRT_DW;
    localparam int unsigned AW = SQRT_AW;
    localparam int unsigned CW = SQRT_CW;

    sqrt_rec_state_t state;
    sqrt_rec_state_t state_nxt;

    logic [QW-1:0] mcand;
    logic [QW-1:0] mplr;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          last_bit;
    logic          load_out;
    logic          in_ready_nxt;
    logic          out_valid_nxt;
    logic          err_c;
    logic [AW-1:0] addend;
    logic [AW-1:0] acc_sum;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign last_bit = (cnt == CW'(QW - 1));

    // Illegal-pair detection, evaluated on the offered pair at accept
`ifdef SQRT_RANGE_CHECK_EN
    always_comb begin
        err_c = (in_r > {in_q, 1'b0});
    end
`else
    always_comb begin
        err_c = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_BUSY;
            ST_BUSY: if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; handshake flags follow the state being entered so they
    // can be registered without adding a cycle
    always_comb begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        load_out      = 1'b0;
        case (state_nxt)
            ST_IDLE: in_ready_nxt  = 1'b1;
            ST_DONE: out_valid_nxt = 1'b1;
            default: ;
        endcase
        if ((state == ST_BUSY) && (state_nxt == ST_DONE)) begin
            load_out = 1'b1;
        end
    end

    // Shift-add step: add the multiplicand weighted by the current bit position
    always_comb begin
        addend  = mplr[0] ? (AW'(mcand) << cnt) : '0;
        acc_sum = acc + addend;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= in_q;
            mplr  <= in_q;
            acc   <= AW'(in_r);
            cnt   <= '0;
        end else if (state == ST_BUSY) begin
            acc   <= acc_sum;
            mplr  <= mplr >> 1;
            cnt   <= cnt + CW'(1);
        end
    end

    // Registered outputs; result fields are captured on the final BUSY edge
    // and held until the next pair completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_d     <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            if (load_out) begin
                out_d   <= acc_sum[DW-1:0];
                out_ovf <= |acc_sum[AW-1:DW];
            end
            if (accept) begin
                out_err <= err_c;
            end
        end
    end

endmodule : sqrt_reconstruct_seq

// File: tb/tb_sqrt_reconstruct_seq.sv
// Scoreboard bench for sqrt_reconstruct_seq: expected results are queued at
// accept time and a negedge monitor retires them on each output handshake.
module tb_sqrt_reconstruct_seq;

    typedef struct packed {
        logic [31:0] d;
        logic        ovf;
        logic        err;
    } exp_t;

`ifdef SQRT_RANGE_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_q;
    logic [16:0] in_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic        out_ovf;
    logic        out_err;

    int   checks = 0;
    int   errors = 0;
    bit   rand_stall = 1'b0;
    exp_t sb[$];

    sqrt_reconstruct_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the definition D = Q*Q + R
    function automatic exp_t model(input int unsigned q, input int unsigned r);
        exp_t            m;
        longint unsigned full;
        full  = longint'(q) * longint'(q) + longint'(r);
        m.d   = full[31:0];
        m.ovf = (full >= 64'h1_0000_0000);
        m.err = ERR_EN && (r > 2 * q);
        return m;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic ovf, input logic err);
        exp_t m;
        m.d   = d;
        m.ovf = ovf;
        m.err = err;
        return m;
    endfunction

    // Offer a pair until accepted, then queue its expected result
    task automatic send(input logic [15:0] q, input logic [16:0] r, input exp_t e);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_q     = q;
            in_r     = r;
            ok       = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (ok) sb.push_back(e);
        else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout q=%0h r=%0h", q, r);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    // Random output backpressure
    always @(posedge clk) begin
        if (rand_stall) #1 out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: retire on handshake, check hold-stability while stalled
    logic [31:0] pd;
    logic        po, pe, pv;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv = 1'b0;
        end else if (out_valid) begin
            chk("in_ready_low_in_done", 64'(in_ready), 64'(0));
            if (pv) begin
                chk("stall_hold_d",   64'(out_d),   64'(pd));
                chk("stall_hold_ovf", 64'(out_ovf), 64'(po));
                chk("stall_hold_err", 64'(out_err), 64'(pe));
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_d);
                end else begin
                    e = sb.pop_front();
                    chk("out_d",   64'(out_d),   64'(e.d));
                    chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
                    chk("out_err", 64'(out_err), 64'(e.err));
                end
                pv = 1'b0;
            end else begin
                pv = 1'b1;
                pd = out_d;
                po = out_ovf;
                pe = out_err;
            end
        end else begin
            pv = 1'b0;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_d"},     64'(out_d),     64'(0));
        chk({tag, "_out_ovf"},   64'(out_ovf),   64'(0));
        chk({tag, "_out_err"},   64'(out_err),   64'(0));
    endtask

    initial begin
        int          n;
        logic [15:0] q;
        logic [16:0] r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_q      = '0;
        in_r      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk) rst = 1'b0;

        // Latency and boundary pairs
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(16'h0000, 17'h00000, mk(32'h0000_0000, 1'b0, 1'b0));
        wait_valid(n);
        chk("latency_cycles", 64'(n), 64'(16));
        send(16'hFFFF, 17'h1FFFE, mk(32'hFFFF_FFFF, 1'b0, 1'b0));
        send(16'hFFFF, 17'h1FFFF, mk(32'h0000_0000, 1'b1, ERR_EN));
        send(16'd3,    17'd5,     mk(32'd14,        1'b0, 1'b0));
        send(16'd3,    17'd7,     mk(32'd16,        1'b0, ERR_EN));
        send(16'd1000, 17'd0,     mk(32'd1000000,   1'b0, 1'b0));

        // Backpressure: held DONE ignores new offers
        wait_valid(n);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(16'd7, 17'd2, mk(32'd51, 1'b0, 1'b0));
        wait_valid(n);
        chk("stall_reached_done", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_q     = 16'($urandom);
            in_r     = 17'($urandom);
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready",  64'(in_ready),  64'(1));
        chk("release_out_valid", 64'(out_valid), 64'(0));

        // Reset in the middle of BUSY discards the pair
        send(16'h1234, 17'h00005, mk(32'h014B_5A95, 1'b0, 1'b0));
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(16'd12, 17'd20, mk(32'd164, 1'b0, 1'b0));

        // Random legal pairs, back-to-back with random stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            q = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
            r = 17'($urandom_range(0, 2 * int'(q)));
            send(q, r, model(q, r));
        end

        // Drain
        rand_stall = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_remaining", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sqrt_reconstruct_seq
